// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the RISC-V core: widths, the bubble encoding,
// the fetch FSM state type and the IF/ID register payload.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // A bubble keeps the PC fields of the current contents and only kills the instruction.
    function automatic if_id_t make_bubble(input if_id_t cur, input logic [XLEN-1:0] nop);
        if_id_t b;
        b       = cur;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: rst > flush (bubble) > stall (hold) > load > bubble.
// The same pattern is meant to be reused for later pipeline registers.
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   stall,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // Register update with flush/stall/load priority; idle cycles insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '{pc: '0, pc4: '0, instr: BUBBLE_INSTR, valid: 1'b0};
        end else if (flush) begin
            q <= make_bubble(q, BUBBLE_INSTR);
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end else begin
            q <= make_bubble(q, BUBBLE_INSTR);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake
// (imem_req is a one-cycle request pulse, imem_rvalid a one-cycle response
// pulse at least one cycle later, never more than one request in flight),
// and the IF/ID register feeding decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/bubble/redirect counters.
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            stall_IF_ID,
    input  logic            flush_IF_ID,
    input  logic            BRANCHTAKEN_EX,
    input  logic [XLEN-1:0] BRANCH_TARGET_EX,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] PC4_ID,
    output logic [XLEN-1:0] INSTR_ID,
    output logic            VALID_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_bubble_cycles,
    output logic [31:0]     perf_redirects
`endif
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_plus4, target, hold_instr;
    logic            redirect, ifid_load, hold_capture;
    if_id_t          ifid_data, ifid_q;

    // A redirect needs PCWrite; without it the PC may not change at all.
    assign redirect = BRANCHTAKEN_EX & PCWrite;
    assign target   = BRANCH_TARGET_EX & ~XLEN'(3);
    assign pc_plus4 = pc + XLEN'(4);

    // A redirect in ISSUE suppresses the request so the old PC is never fetched.
    assign imem_req  = (state == ISSUE) && !rst && !redirect;
    assign imem_addr = pc;

    // Next-state, next-PC and IF/ID load selection.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ifid_load    = 1'b0;
        hold_capture = 1'b0;
        ifid_data    = '{pc: pc, pc4: pc_plus4, instr: imem_rdata, valid: 1'b1};
        if (redirect) begin
            pc_nxt = target;
            // A response still in flight must be swallowed before issuing again.
            if ((state == WAIT || state == DISCARD) && !imem_rvalid) begin
                state_nxt = DISCARD;
            end else begin
                state_nxt = ISSUE;
            end
        end else begin
            case (state)
                ISSUE: state_nxt = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (flush_IF_ID) begin
                            // Response dropped, PC unchanged: the same address is refetched.
                            state_nxt = ISSUE;
                        end else if (stall_IF_ID) begin
                            hold_capture = 1'b1;
                            state_nxt    = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            if (PCWrite) pc_nxt = pc_plus4;
                            state_nxt = ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (flush_IF_ID) begin
                        state_nxt = ISSUE;
                    end else if (!stall_IF_ID) begin
                        ifid_data.instr = hold_instr;
                        ifid_load       = 1'b1;
                        if (PCWrite) pc_nxt = pc_plus4;
                        state_nxt = ISSUE;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) state_nxt = ISSUE;
                end
                default: state_nxt = ISSUE;
            endcase
        end
    end

    // FSM state, PC and the hold register for responses that arrive during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            hold_instr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (hold_capture) hold_instr <= imem_rdata;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect | flush_IF_ID),
        .stall(stall_IF_ID),
        .load (ifid_load),
        .d    (ifid_data),
        .q    (ifid_q)
    );

    assign PC_ID    = ifid_q.pc;
    assign PC4_ID   = ifid_q.pc4;
    assign INSTR_ID = ifid_q.instr;
    assign VALID_ID = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic bubble_load;
    assign bubble_load = redirect | flush_IF_ID | (!stall_IF_ID & !ifid_load);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles  <= '0;
            perf_bubble_cycles <= '0;
            perf_redirects     <= '0;
        end else begin
            if (stall_IF_ID && perf_stall_cycles != '1)  perf_stall_cycles  <= perf_stall_cycles + 32'd1;
            if (bubble_load && perf_bubble_cycles != '1) perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
            if (redirect && perf_redirects != '1)        perf_redirects     <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized hazards,
// checked against a flag-based reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b1, stall_IF_ID = 1'b0, flush_IF_ID = 1'b0, BRANCHTAKEN_EX = 1'b0;
    logic [31:0] BRANCH_TARGET_EX = '0;
    logic        imem_req, imem_rvalid = 1'b0, VALID_ID;
    logic [31:0] imem_addr, imem_rdata = '0, PC_ID, PC4_ID, INSTR_ID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bubble_cycles, perf_redirects;
`endif

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .stall_IF_ID(stall_IF_ID),
        .flush_IF_ID(flush_IF_ID), .BRANCHTAKEN_EX(BRANCHTAKEN_EX),
        .BRANCH_TARGET_EX(BRANCH_TARGET_EX), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PC_ID(PC_ID), .PC4_ID(PC4_ID),
        .INSTR_ID(INSTR_ID), .VALID_ID(VALID_ID)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_bubble_cycles(perf_bubble_cycles),
        .perf_redirects(perf_redirects)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory environment: one pending request, response after mem_lat cycles.
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat  = 1;
    logic        rand_lat = 1'b0;

    // Reference model: fetch progress kept as flags, not as an FSM encoding.
    logic        m_known = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_out = 1'b0, m_drop = 1'b0, m_held = 1'b0;
    logic [31:0] m_held_word = '0;
    logic [31:0] e_pc = '0, e_pc4 = '0, e_instr = '0;
    logic        e_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h0000_1357;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, pw, st, fl, br, input logic [31:0] tgt,
                                input logic rv, input logic [31:0] rd);
        logic redirect, have_new, advance, issuing;
        if (r) begin
            m_known = 1'b1;
            m_pc = RESET_PC;
            m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
            e_pc = '0; e_pc4 = '0; e_instr = NOP; e_valid = 1'b0;
            return;
        end
        if (!m_known) return;
        redirect = br && pw;
        have_new = m_out && rv;
        issuing  = !m_out && !m_drop && !m_held && !redirect;
        advance  = 1'b0;
        if (redirect || fl || (!st && !have_new && !m_held)) begin
            e_instr = NOP;
            e_valid = 1'b0;
        end else if (!st) begin
            e_pc    = m_pc;
            e_pc4   = m_pc + 32'd4;
            e_instr = have_new ? rd : m_held_word;
            e_valid = 1'b1;
            advance = pw;
        end
        if (redirect) begin
            m_pc   = {tgt[31:2], 2'b00};
            m_drop = (m_out || m_drop) && !rv;
            m_out  = 1'b0;
            m_held = 1'b0;
        end else begin
            if (m_drop && rv) m_drop = 1'b0;
            if (have_new) begin
                m_out = 1'b0;
                if (!fl && st) begin
                    m_held = 1'b1;
                    m_held_word = rd;
                end
            end else if (m_held && (fl || !st)) begin
                m_held = 1'b0;
            end
            if (issuing) m_out = 1'b1;
            if (advance) m_pc = m_pc + 32'd4;
        end
    endtask

    // Driver: one clock cycle with the given controls; frv injects a stray response.
    task automatic step(input logic r, pw, st, fl, br, input logic [31:0] tgt, input logic frv);
        logic due, exp_req;
        @(negedge clk);
        if (m_known) begin
            chk("pc_id", PC_ID, e_pc);
            chk("pc4_id", PC4_ID, e_pc4);
            chk("instr_id", INSTR_ID, e_instr);
            chk("valid_id", {31'b0, VALID_ID}, {31'b0, e_valid});
        end
        due = mem_pend && (mem_cnt == 0);
        rst = r; PCWrite = pw; stall_IF_ID = st; flush_IF_ID = fl;
        BRANCHTAKEN_EX = br; BRANCH_TARGET_EX = tgt;
        imem_rvalid = due || frv;
        imem_rdata  = due ? mem_word(mem_addr) : (frv ? 32'hDEAD_BEEF : $urandom);
        if (due) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        #1;
        exp_req = !r && m_known && !m_out && !m_drop && !m_held && !(br && pw);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (m_known) chk("imem_addr", imem_addr, m_pc);
        if (imem_req === 1'b1) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (rand_lat ? $urandom_range(1, 3) : mem_lat) - 1;
        end
        model_update(r, pw, st, fl, br, tgt, imem_rvalid, imem_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int   bound;
        logic r, pw, st, fl, br;
        logic [31:0] tgt;

        // Reset, then plain 1-cycle-latency fetching: addresses 0,4,8 with bubbles between.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(6);

        // Advance to an ISSUE at PC=0x10.
        bound = 0;
        while (!(m_pc == 32'h10 && !m_out && !m_drop && !m_held) && bound < 40) begin
            idle(1);
            bound++;
        end
        checks++;
        if (bound >= 40) begin
            errors++;
            $error("FAIL reach_pc10 observed_cycles=%0d expected_below=40", bound);
        end

        // Stall with PCWrite=0 across the response for 0x10, then release.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(3);

        // Redirect while a slow response is outstanding: response must be discarded.
        mem_lat = 3;
        bound = 0;
        while (m_out !== 1'b0 || m_drop || m_held) begin
            idle(1);
            bound++;
            if (bound > 10) break;
        end
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0201, 1'b0);
        idle(8);

        // Redirect and stall together: redirect wins.
        mem_lat = 1;
        idle(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
        idle(4);

        // PC wrap: fetch 0xFFFF_FFFC, PC4_ID wraps to 0 and the next fetch is at 0.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(5);

        // Flush alone.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(3);

        // Reset in WAIT with the response landing one cycle after reset.
        mem_lat = 2;
        bound = 0;
        while ((!m_out || m_drop || m_held) && bound < 10) begin
            idle(1);
            bound++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(6);

        // Randomized hazards with variable memory latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            pw  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = pw && ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(r, pw, st, fl, br, tgt, ($urandom_range(0, 49) == 0) && r);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
